poly_tobytes_stream: RTL



---
 rtl/poly_tobytes_stream_if.sv | 28 ++
 rtl/poly_tobytes_stream.sv | 135 +++++++++++++
 2 files changed

// File: rtl/poly_tobytes_stream_if.sv
// Stream bundle between the basemul-accumulate stage, the byte packer and
// the byte-oriented output/hash path.
interface poly_tobytes_stream_if #(
    parameter int DEPTH = 8
);
    logic               readin;
    logic               in_ready;
    logic [15:0]        din_1;
    logic [15:0]        din_2;
    logic [DEPTH-1:0]   in_index;
    logic               readout;
    logic [7:0]         dout;
    logic               dout_valid;
    logic [DEPTH:0]     out_index;
    logic               done;

    // Producer/consumer side (drives pairs in, takes bytes out)
    modport master (
        output readin, din_1, din_2, in_index, readout,
        input  in_ready, dout, dout_valid, out_index, done
    );

    // Packer side
    modport slave (
        input  readin, din_1, din_2, in_index, readout,
        output in_ready, dout, dout_valid, out_index, done
    );
endinterface

// File: rtl/poly_tobytes_stream.sv
// Packs a stream of signed coefficient pairs into the Kyber 12-bit byte
// encoding (3 bytes per pair), one byte per cycle, through a 2-entry FIFO.
module poly_tobytes_stream #(
    parameter int DEPTH   = 8,
    parameter int KYBER_Q = 3329
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set,
    poly_tobytes_stream_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [11:0]        r_t0   [2];
    logic [11:0]        r_t1   [2];
    logic [DEPTH-2:0]   r_pair [2];
    logic               r_head;
    logic [1:0]         r_count;

    logic               w_in_ready;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_byte_xfer;
    logic               w_tail;
    logic [DEPTH:0]     w_pair_ext;
    logic [DEPTH:0]     w_base;
    logic [7:0]         w_dout;
    logic [DEPTH:0]     w_out_index;

    // Map a signed coefficient into [0, q); only the low 12 bits are kept,
    // so a 16-bit wrapping add is sufficient.
    function automatic logic [11:0] to_pos(input logic [15:0] x);
        logic [15:0] s;
        s = x[15] ? (x + 16'(KYBER_Q)) : x;
        return s[11:0];
    endfunction

    assign w_in_ready  = (r_state != S_DONE) && (r_count < 2'd2);
    assign w_valid     = (r_state == S_B0) || (r_state == S_B1) || (r_state == S_B2);
    assign w_push      = set & bus.readin & w_in_ready;
    assign w_byte_xfer = set & w_valid & bus.readout;
    // With fewer than two entries the free slot is head+count (mod 2)
    assign w_tail      = r_head ^ r_count[0];
    assign w_pair_ext  = {2'b00, r_pair[r_head]};
    assign w_base      = (w_pair_ext << 1) + w_pair_ext;

    // Byte sequencer: next state, pop decision and head-entry byte select
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dout      = '0;
        w_out_index = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd0) w_state_nxt = S_B0;
            end
            S_B0: begin
                w_dout      = r_t0[r_head][7:0];
                w_out_index = w_base;
                if (w_byte_xfer) w_state_nxt = S_B1;
            end
            S_B1: begin
                w_dout      = {r_t1[r_head][3:0], r_t0[r_head][11:8]};
                w_out_index = w_base + (DEPTH+1)'(1);
                if (w_byte_xfer) w_state_nxt = S_B2;
            end
            S_B2: begin
                w_dout      = r_t1[r_head][11:4];
                w_out_index = w_base + (DEPTH+1)'(2);
                if (w_byte_xfer) begin
                    w_pop = 1'b1;
                    if (r_pair[r_head] == '1)
                        w_state_nxt = S_DONE;
                    else if ((r_count > 2'd1) || w_push)
                        w_state_nxt = S_B0;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; everything freezes while set is low
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else if (set)
            r_state <= w_state_nxt;
    end

    // Pair FIFO: write at tail on push, advance head on pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_t0[w_tail]   <= to_pos(bus.din_1);
                r_t1[w_tail]   <= to_pos(bus.din_2);
                r_pair[w_tail] <= bus.in_index[DEPTH-1:1];
            end
            if (w_pop)
                r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.dout_valid = w_valid;
    assign bus.dout       = w_dout;
    assign bus.out_index  = w_out_index;
    assign bus.done       = (r_state == S_DONE);

endmodule
